// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : widths, ALU opcodes, instruction classes and state encodings
//           shared by the control unit and the datapath.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_BITS  = 5;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHL  = 4'd6;
   localparam logic [3:0] OP_SHR  = 4'd7;
   localparam logic [3:0] OP_PASA = 4'd8;
   localparam logic [3:0] OP_PASB = 4'd9;
   localparam logic [3:0] OP_INC  = 4'd10;
   localparam logic [3:0] OP_DEC  = 4'd11;
   localparam logic [3:0] OP_SLT  = 4'd12;
   localparam logic [3:0] OP_NOP  = 4'd15;

   localparam logic [1:0] CLS_STD_OP = 2'd0;
   localparam logic [1:0] CLS_LOADR  = 2'd1;
   localparam logic [1:0] CLS_STORER = 2'd2;

   typedef enum logic [2:0] {
      CU_RESET  = 3'd0,
      CU_FETCH  = 3'd1,
      CU_DECODE = 3'd2,
      CU_EXEC   = 3'd3,
      CU_MEM    = 3'd4,
      CU_WB     = 3'd5
   } cu_state_t;

   typedef enum logic {
      DP_INIT = 1'b0,
      DP_RUN  = 1'b1
   } dp_state_t;

endpackage

`default_nettype wire

// File: rtl/dp_alu.sv
// ---------------------------------------------------------------------------
// dp_alu : combinational ALU, results modulo 2^DATA_WIDTH.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dp_alu
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [3:0]            opcode,
   output logic [DATA_WIDTH-1:0] result
);

   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SHL:  result = a << 1;
         OP_SHR:  result = a >> 1;
         OP_PASA: result = a;
         OP_PASB: result = b;
         OP_INC:  result = a + 1'b1;
         OP_DEC:  result = a - 1'b1;
         OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
         default: result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/datapath_unit.sv
// ---------------------------------------------------------------------------
// datapath_unit : ALU plus self-clearing data memory answering the control
//                 unit with a registered result2.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module datapath_unit
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] operand1,
   input  logic [DATA_WIDTH-1:0] operand2,
   input  logic [DATA_WIDTH-1:0] offset,
   input  logic [3:0]            opcode,
   input  logic                  sel1,
   input  logic                  sel3,
   input  logic                  w_r,
   output logic [DATA_WIDTH-1:0] result2,
   output logic                  zero,
   output logic                  ready
);

   localparam int MEM_WORDS = 1 << ADDR_BITS;

   dp_state_t             state;
   logic [ADDR_BITS-1:0]  clr_cnt;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [DATA_WIDTH-1:0] alu_b;
   logic [DATA_WIDTH-1:0] alu_out;
   logic [ADDR_BITS-1:0]  addr;
   logic [DATA_WIDTH-1:0] alu_q;
   logic [DATA_WIDTH-1:0] rd_q;
   logic                  sel1_q;

   assign alu_b = sel3 ? offset : operand2;
   assign addr  = alu_out[ADDR_BITS-1:0];

   dp_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .a      (operand1),
      .b      (alu_b),
      .opcode (opcode),
      .result (alu_out)
   );

   // The array has no reset; INIT sweeps it to zero, and rst blocks any write
   // on its own edge so an interrupted store never lands.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == DP_INIT) begin
            mem[clr_cnt] <= '0;
         end else if (w_r) begin
            mem[addr] <= operand2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DP_INIT;
         clr_cnt <= '0;
         ready   <= 1'b0;
         alu_q   <= '0;
         rd_q    <= '0;
         sel1_q  <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state)
            DP_INIT: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == {ADDR_BITS{1'b1}}) begin
                  state <= DP_RUN;
                  ready <= 1'b1;
               end
            end
            DP_RUN: begin
               alu_q  <= alu_out;
               rd_q   <= mem[addr];
               sel1_q <= sel1;
               zero   <= (alu_out == '0);
            end
            default: state <= DP_INIT;
         endcase
      end
   end

   assign result2 = sel1_q ? alu_q : rd_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_unit.sv
// ---------------------------------------------------------------------------
// tb_datapath_unit : scoreboard bench for datapath_unit with a reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_datapath_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] operand1, operand2, offset;
   logic [3:0] opcode;
   logic       sel1, sel3, w_r;
   wire  [7:0] result2;
   wire        zero, ready;

   int tests = 0;
   int fails = 0;
   int exp_res_q[$];
   int exp_z_q[$];
   int ref_mem[32];

   always #5 clk = ~clk;

   datapath_unit dut (
      .clk      (clk),
      .rst      (rst),
      .operand1 (operand1),
      .operand2 (operand2),
      .offset   (offset),
      .opcode   (opcode),
      .sel1     (sel1),
      .sel3     (sel3),
      .w_r      (w_r),
      .result2  (result2),
      .zero     (zero),
      .ready    (ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_alu(input int a, input int b, input int op);
      int r;
      case (op)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a & b;
         3:  r = a | b;
         4:  r = a ^ b;
         5:  r = 255 - a;
         6:  r = a * 2;
         7:  r = a / 2;
         8:  r = a;
         9:  r = b;
         10: r = a + 1;
         11: r = a - 1;
         12: r = (a < b) ? 1 : 0;
         default: r = 0;
      endcase
      return r & 255;
   endfunction

   // Drive one instruction; if the DUT will honour it, queue what it must answer.
   task automatic drive(input int a, input int b, input int off, input int op,
                        input int s1, input int s3, input int wr);
      int alu, adr, rd;
      operand1 = 8'(a); operand2 = 8'(b); offset = 8'(off);
      opcode = 4'(op); sel1 = s1[0]; sel3 = s3[0]; w_r = wr[0];
      if (ready === 1'b1 && rst === 1'b0) begin
         alu = ref_alu(a, s3 ? off : b, op);
         adr = alu % 32;
         rd  = ref_mem[adr];
         exp_res_q.push_back(s1 ? alu : rd);
         exp_z_q.push_back(alu == 0 ? 1 : 0);
         if (wr != 0) ref_mem[adr] = b & 255;
      end
      @(posedge clk); #1;
   endtask

   // Hold reset, optionally interrupt INIT once, then measure INIT length.
   task automatic reset_seq(input int rst_cycles, input bit abort_init);
      int n;
      operand1 = 8'd9; operand2 = 8'hFF; offset = 8'd0;
      opcode = 4'd8; sel1 = 1'b0; sel3 = 1'b0; w_r = 1'b1;
      rst = 1'b1;
      repeat (rst_cycles) @(posedge clk);
      #1 rst = 1'b0;
      if (abort_init) begin
         repeat (10) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
      end
      foreach (ref_mem[i]) ref_mem[i] = 0;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         if (n == 5) begin
            chk("init_result2", result2, 0);
            chk("init_zero", zero, 0);
         end
         @(posedge clk); #1;
         n++;
      end
      chk("init_cycles", n, 32);
      w_r = 1'b0;
   endtask

   task automatic sweep_mem();
      for (int i = 0; i < 32; i++) drive(i, 0, 0, 8, 0, 0, 0);
   endtask

   initial begin : monitor
      int r, z;
      forever begin
         @(posedge clk);
         if (exp_res_q.size() > 0) begin
            @(negedge clk);
            r = exp_res_q.pop_front();
            z = exp_z_q.pop_front();
            chk("result2", result2, r);
            chk("zero", zero, z);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst = 1'b1;
      operand1 = '0; operand2 = '0; offset = '0;
      opcode = '0; sel1 = 1'b0; sel3 = 1'b0; w_r = 1'b0;

      reset_seq(2, 1'b0);
      chk("ready_after_init", ready, 1);
      chk("result2_after_init", result2, 0);
      sweep_mem();

      drive(200, 100, 0, 0, 1, 0, 0);      // 200+100 wraps to 44
      drive(7, 7, 0, 1, 1, 0, 0);          // SUB to zero
      drive(33, 44, 0, 15, 1, 0, 0);       // NOP answers 0
      drive(3, 8'hA5, 4, 0, 0, 1, 1);      // store A5 at 7
      drive(3, 0, 4, 0, 0, 1, 0);          // load it back
      drive(35, 0, 4, 0, 0, 1, 0);         // 39 wraps to address 7
      drive(9, 8'h3C, 0, 8, 0, 0, 1);      // read-first: old value
      drive(9, 0, 0, 8, 0, 0, 0);          // new value next cycle
      drive(1, 8'h5A, 0, 15, 0, 0, 1);     // NOP store lands at mem[0]
      drive(0, 0, 0, 8, 0, 0, 0);
      drive(3, 8'h77, 4, 0, 0, 1, 1);      // repeated store is idempotent
      drive(3, 8'h77, 4, 0, 0, 1, 1);
      drive(3, 0, 4, 0, 0, 1, 0);

      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
               $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 2) == 0) ? 1 : 0);
      end
      sweep_mem();

      reset_seq(1, 1'b0);                  // reset lands on a pending store
      sweep_mem();
      drive(12, 8'hC3, 0, 8, 0, 0, 1);
      reset_seq(1, 1'b1);                  // reset again in the middle of INIT
      sweep_mem();

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_res_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
